// File: rtl/sa_ctrl_axil_slave.sv
// AXI4-Lite control/status slave for the systolic-array DMA pipeline.
// Decodes host writes into the start pulse, DMA bases and transfer sizes.
// Also captures busy/done/error status, counts busy cycles and drives a level IRQ.
module sa_ctrl_axil_slave #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] RST_NUM_TRANS      = 32'd16,
  parameter logic [31:0] RST_MAX_BLK        = 32'd2,
  parameter logic [31:0] VERSION            = 32'h0001_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            o_start,
  output logic [31:0]                     o_read_base_addr,
  output logic [31:0]                     o_write_base_addr,
  output logic [31:0]                     o_num_trans_param,
  output logic [31:0]                     o_max_blk_param,
  input  logic                            i_busy,
  input  logic                            i_done,
  input  logic                            i_error,
  output logic                            o_irq
);

  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_STATUS    = 3'd1,
    REG_RD_BASE   = 3'd2,
    REG_WR_BASE   = 3'd3,
    REG_NUM_TRANS = 3'd4,
    REG_MAX_BLK   = 3'd5,
    REG_CYCLES    = 3'd6,
    REG_VERSION   = 3'd7
  } reg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write holding registers
  logic        aw_held_q, w_held_q;
  reg_e        awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  // Read response registers
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_d;

  // Control/status state
  logic        start_q, irq_en_q, done_q, err_q, done_prev_q;
  logic [31:0] rd_base_q, wr_base_q, num_trans_q, max_blk_q, cycles_q;

  // Decode strobes
  logic aw_hs, w_hs, ar_hs, commit, sel_rw, drop_busy, start_acc;
  logic done_rise, done_clr, err_clr;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Ready flags are gated by reset so they drop immediately when reset asserts
  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_held_q  & ~bvalid_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~rvalid_q;

  // Handshake, commit and status-event decode
  always_comb begin
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID  & S_AXI_WREADY;
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    commit    = aw_held_q & w_held_q & ~bvalid_q;
    sel_rw    = (awaddr_q == REG_RD_BASE) || (awaddr_q == REG_WR_BASE) ||
                (awaddr_q == REG_NUM_TRANS) || (awaddr_q == REG_MAX_BLK);
    drop_busy = commit & sel_rw & i_busy;
    start_acc = commit & (awaddr_q == REG_CTRL) & wstrb_q[0] & wdata_q[0] &
                ~i_busy & ~start_q;
    done_clr  = commit & (awaddr_q == REG_STATUS) & wstrb_q[0] & wdata_q[1];
    err_clr   = commit & (awaddr_q == REG_STATUS) & wstrb_q[0] & wdata_q[2];
    done_rise = i_done & ~done_prev_q;
  end

  // Read mux: values sampled before the edge that captures them
  always_comb begin
    rdata_d = '0;
    case (reg_e'(S_AXI_ARADDR[4:2]))
      REG_CTRL:      rdata_d = {30'd0, irq_en_q, 1'b0};
      REG_STATUS:    rdata_d = {29'd0, err_q, done_q, i_busy};
      REG_RD_BASE:   rdata_d = rd_base_q;
      REG_WR_BASE:   rdata_d = wr_base_q;
      REG_NUM_TRANS: rdata_d = num_trans_q;
      REG_MAX_BLK:   rdata_d = max_blk_q;
      REG_CYCLES:    rdata_d = cycles_q;
      REG_VERSION:   rdata_d = VERSION;
    endcase
  end

  // Write channel: independent AW/W capture, commit, and B response
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= REG_CTRL;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= reg_e'(S_AXI_AWADDR[4:2]);
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= drop_busy ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Host-writable parameter registers and the one-cycle start pulse
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      start_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      num_trans_q <= RST_NUM_TRANS;
      max_blk_q   <= RST_MAX_BLK;
    end else begin
      start_q <= start_acc;
      if (commit && !drop_busy) begin
        case (awaddr_q)
          REG_CTRL:      if (wstrb_q[0]) irq_en_q <= wdata_q[1];
          REG_RD_BASE:   rd_base_q   <= merge_bytes(rd_base_q,   wdata_q, wstrb_q);
          REG_WR_BASE:   wr_base_q   <= merge_bytes(wr_base_q,   wdata_q, wstrb_q);
          REG_NUM_TRANS: num_trans_q <= merge_bytes(num_trans_q, wdata_q, wstrb_q);
          REG_MAX_BLK:   max_blk_q   <= merge_bytes(max_blk_q,   wdata_q, wstrb_q);
          default: ;
        endcase
      end
    end
  end

  // Sticky status and cycle counter; start clear beats set, set beats W1C
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      done_prev_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cycles_q    <= '0;
    end else begin
      done_prev_q <= i_done;
      if (start_acc)      done_q <= 1'b0;
      else if (done_rise) done_q <= 1'b1;
      else if (done_clr)  done_q <= 1'b0;
      if (start_acc)      err_q <= 1'b0;
      else if (i_error)   err_q <= 1'b1;
      else if (err_clr)   err_q <= 1'b0;
      if (start_acc)                      cycles_q <= '0;
      else if (i_busy && cycles_q != '1)  cycles_q <= cycles_q + 32'd1;
    end
  end

  // Read channel: capture on AR handshake, hold until R handshake
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= RESP_OKAY;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID      = bvalid_q;
  assign S_AXI_BRESP       = bresp_q;
  assign S_AXI_RVALID      = rvalid_q;
  assign S_AXI_RDATA       = rdata_q;
  assign S_AXI_RRESP       = rresp_q;
  assign o_start           = start_q;
  assign o_read_base_addr  = rd_base_q;
  assign o_write_base_addr = wr_base_q;
  assign o_num_trans_param = num_trans_q;
  assign o_max_blk_param   = max_blk_q;
  assign o_irq             = done_q & irq_en_q;

endmodule

// File: tb/tb_sa_ctrl_axil_slave.sv
// Directed self-checking bench for sa_ctrl_axil_slave.
module tb_sa_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        o_start, o_irq;
  logic [31:0] rd_base, wr_base, num_trans, max_blk;
  logic        i_busy, i_done, i_error;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  sa_ctrl_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .o_start(o_start), .o_read_base_addr(rd_base), .o_write_base_addr(wr_base),
    .o_num_trans_param(num_trans), .o_max_blk_param(max_blk),
    .i_busy(i_busy), .i_done(i_done), .i_error(i_error), .o_irq(o_irq)
  );

  // Counts cycles in which the start pulse is high
  always @(negedge clk) if (o_start === 1'b1) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    int n;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    check("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    step();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    check("rd_rvalid_seen", {31'd0, rvalid}, 32'd1);
    d = rdata;
    step();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] rst_exp [8];
    rst_exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd16, 32'd2, 32'd0, 32'h0001_0000};

    rst_n = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1; i_busy = 1'b0; i_done = 1'b0; i_error = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata, 32'd0);
    check("rst_start",   {31'd0, o_start}, 32'd0);
    check("rst_irq",     {31'd0, o_irq},   32'd0);
    check("rst_num_trans", num_trans, 32'd16);
    check("rst_max_blk",   max_blk,   32'd2);
    rst_n = 1'b1;
    step();
    check("idle_awready", {31'd0, awready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd(5'(i * 4), d);
      check($sformatf("rd_rst_%0d", i), d, rst_exp[i]);
    end

    // AW then W on separate cycles
    awaddr = 5'h08; awvalid = 1'b1; bready = 1'b1;
    step();
    check("sep_awready_held", {31'd0, awready}, 32'd0);
    check("sep_wready_open",  {31'd0, wready},  32'd1);
    awvalid = 1'b0; wdata = 32'h1000_0000; wstrb = 4'hF; wvalid = 1'b1;
    step();
    check("sep_bvalid_early", {31'd0, bvalid}, 32'd0);
    wvalid = 1'b0;
    step();
    check("sep_bvalid", {31'd0, bvalid}, 32'd1);
    check("sep_bresp",  {30'd0, bresp},  32'd0);
    check("sep_rd_base", rd_base, 32'h1000_0000);
    step();
    check("sep_bvalid_once", {31'd0, bvalid}, 32'd0);
    wr(5'h08, 32'h0000_00FF, 4'b0001, r);
    check("strb_resp", {30'd0, r}, 32'd0);
    check("strb_rd_base", rd_base, 32'h1000_00FF);

    // Start, busy period, completion, IRQ and W1C
    start_cnt = 0;
    wr(5'h00, 32'h3, 4'hF, r);
    repeat (3) step();
    check("start_pulse_cnt", start_cnt, 32'd1);
    rd(5'h00, d);
    check("ctrl_read", d, 32'h2);
    i_busy = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    i_busy = 1'b0; i_done = 1'b1;
    step();
    check("done_irq", {31'd0, o_irq}, 32'd1);
    rd(5'h04, d);
    check("status_done", d, 32'h2);
    rd(5'h18, d);
    check("cycles_100", d, 32'd100);
    wr(5'h04, 32'h2, 4'hF, r);
    check("irq_cleared", {31'd0, o_irq}, 32'd0);
    rd(5'h04, d);
    check("status_cleared", d, 32'h0);

    // Writes while busy
    i_busy = 1'b1;
    wr(5'h10, 32'd32, 4'hF, r);
    check("busy_slverr", {30'd0, r}, 32'd2);
    check("busy_num_trans", num_trans, 32'd16);
    start_cnt = 0;
    wr(5'h00, 32'h3, 4'hF, r);
    check("busy_start_resp", {30'd0, r}, 32'd0);
    repeat (3) step();
    check("busy_no_start", start_cnt, 32'd0);
    i_busy = 1'b0;
    wr(5'h10, 32'd32, 4'hF, r);
    check("idle_nt_resp", {30'd0, r}, 32'd0);
    check("idle_num_trans", num_trans, 32'd32);
    check("max_blk_kept", max_blk, 32'd2);

    // DONE set and W1C on the same edge: set wins
    i_done = 1'b0; step();
    i_done = 1'b1; step();
    i_done = 1'b0; step();
    check("done_before_race", {31'd0, o_irq}, 32'd1);
    awaddr = 5'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; i_done = 1'b1;
    step();
    check("race_bvalid", {31'd0, bvalid}, 32'd1);
    step();
    rd(5'h04, d);
    check("race_done_kept", d, 32'h2);
    wr(5'h04, 32'h2, 4'hF, r);
    rd(5'h04, d);
    check("done_w1c", d, 32'h0);

    // ERR sticky, lane-0 strobe required for W1C
    i_error = 1'b1; step();
    i_error = 1'b0; repeat (3) step();
    rd(5'h04, d);
    check("err_sticky", d, 32'h4);
    wr(5'h04, 32'h4, 4'b0010, r);
    rd(5'h04, d);
    check("err_w1c_nolane0", d, 32'h4);
    wr(5'h04, 32'h4, 4'hF, r);
    rd(5'h04, d);
    check("err_w1c", d, 32'h0);

    // Accepted start clears ERR and CYCLES
    i_error = 1'b1; step();
    i_error = 1'b0; step();
    start_cnt = 0;
    wr(5'h00, 32'h3, 4'hF, r);
    i_done = 1'b0;
    repeat (2) step();
    check("start2_pulse_cnt", start_cnt, 32'd1);
    rd(5'h04, d);
    check("start_clears_status", d, 32'h0);
    rd(5'h18, d);
    check("start_clears_cycles", d, 32'd0);

    // Back-pressure on B and R, then reset mid-hold
    awaddr = 5'h0C; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    check("hold_bvalid_up", {31'd0, bvalid}, 32'd1);
    araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    check("hold_rvalid_up", {31'd0, rvalid}, 32'd1);
    check("hold_rresp", {30'd0, rresp}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_bvalid",  {31'd0, bvalid},  32'd1);
      check("hold_bresp",   {30'd0, bresp},   32'd0);
      check("hold_awready", {31'd0, awready}, 32'd0);
      check("hold_wready",  {31'd0, wready},  32'd0);
      check("hold_rvalid",  {31'd0, rvalid},  32'd1);
      check("hold_rdata",   rdata, 32'hCAFE_F00D);
      check("hold_arready", {31'd0, arready}, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("mid_rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("mid_rst_rdata",   rdata, 32'd0);
    check("mid_rst_awready", {31'd0, awready}, 32'd0);
    check("mid_rst_arready", {31'd0, arready}, 32'd0);
    check("mid_rst_wr_base", wr_base, 32'd0);
    check("mid_rst_rd_base", rd_base, 32'd0);
    check("mid_rst_num_trans", num_trans, 32'd16);
    check("mid_rst_irq",     {31'd0, o_irq},   32'd0);
    check("mid_rst_start",   {31'd0, o_start}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_ctrl_axil_slave.md
# sa_ctrl_axil_slave

AXI4-Lite control/status slave that sits directly upstream of the systolic-array DMA pipeline. It decodes host register accesses into the pipeline's start pulse, DMA base addresses and transfer-size parameters, and records the busy/done/error status the pipeline returns. It also counts execution cycles and drives a level interrupt to the PS.

## Interface
- C_S_AXI_ADDR_WIDTH, 5: byte address width (8 word registers).
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- RST_NUM_TRANS, 16: reset value of NUM_TRANS.
- RST_MAX_BLK, 2: reset value of MAX_BLK.
- VERSION, 32'h0001_0000: value returned by the VERSION register.

Ports:
- S_AXI_ACLK  in  1  sole clock; one clock domain, all logic on its rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  AW channel (AWPROT ignored).
- S_AXI_WDATA/WSTRB/WVALID/WREADY  W channel.
- S_AXI_BRESP/BVALID/BREADY  B channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  AR channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  R channel.
- o_start  out  1  one-cycle start pulse to the pipeline.
- o_read_base_addr  out  32  RD_BASE register.
- o_write_base_addr  out  32  WR_BASE register.
- o_num_trans_param  out  32  NUM_TRANS register.
- o_max_blk_param  out  32  MAX_BLK register.
- i_busy, i_done, i_error  in  1 each  status from the pipeline. i_done is a level signal; it rises at completion and falls on the next start.
- o_irq  out  1  level interrupt.

## Operation
Register map (address bits [4:2]):
- 0x00 CTRL: bit0 START (write-1, self-clearing, always reads 0); bit1 IRQ_EN (R/W).
- 0x04 STATUS: bit0 BUSY (RO, = i_busy); bit1 DONE (sticky, write-1-to-clear); bit2 ERR (sticky, write-1-to-clear).
- 0x08 RD_BASE, 0x0C WR_BASE, 0x10 NUM_TRANS, 0x14 MAX_BLK: R/W.
- 0x18 CYCLES: RO. Cleared on an accepted start, +1 each cycle i_busy=1, saturates at 0xFFFF_FFFF.
- 0x1C VERSION: RO.

Write behaviour:
- WSTRB is honoured per byte on R/W registers. For W1C bits and START, only byte-lane 0 matters.
- Writes to RD_BASE, WR_BASE, NUM_TRANS or MAX_BLK while i_busy=1 are dropped and answered with BRESP=SLVERR (2'b10).
- Writes to RO registers are dropped and answered with OKAY.

Start:
- Accepted only when i_busy=0 and o_start=0; otherwise it is ignored and answered with OKAY.
- An accepted start clears DONE, ERR and CYCLES.

Status capture:
- DONE sets on a rising edge of i_done (previous-cycle register).
- ERR sets whenever i_error=1.
- o_irq = DONE & IRQ_EN.

## Timing
- Reset values: all READY/VALID = 0, BRESP = RRESP = 0, RDATA = 0, o_start = 0, o_irq = 0, bases = 0, NUM_TRANS = RST_NUM_TRANS, MAX_BLK = RST_MAX_BLK, IRQ_EN = DONE = ERR = CYCLES = 0.
- Write path: AW and W are accepted independently into holding registers.
  - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID (combinational from registers).
  - The commit edge is the first edge with both held and BVALID=0. At that edge: registers update, BVALID rises, o_start rises if the write is an accepted start, and both held flags clear.
  - Minimum latency: AW and W handshaked together at edge N, BVALID visible after edge N+1.
  - BVALID holds until BREADY is sampled high; no new AW/W is accepted while BVALID=1.
- Read path: ARREADY = !RVALID.
  - On an AR handshake at edge N: RDATA/RRESP register the value sampled at edge N and RVALID=1 after edge N.
  - RDATA is stable until the RREADY handshake.
  - Unmapped addresses cannot occur (8 slots); address bits [1:0] are ignored.
- o_start is high for exactly one cycle, the cycle after the commit edge.
- Simultaneous events:
  - A DONE set and a W1C clear on the same edge: set wins.
  - An accepted start and an i_done rising edge on the same edge: start clear wins.
  - A read of STATUS on the same edge as a status change returns the pre-edge value.
- If reset asserts mid-transaction, all channels return to reset values immediately. A pending B/R response is dropped.

## Test plan
- Reset → read 0x10 = 16, 0x14 = 2, 0x1C = 0x0001_0000, all others 0; o_irq = 0.
- AW then W on separate cycles, writing 0x08 ← 0x1000_0000 → BRESP = OKAY once, o_read_base_addr = 0x1000_0000. Repeat with WSTRB = 4'b0001 and data 0xFF → only bits [7:0] change.
- Write CTRL = 0x3 with i_busy=0 → o_start high for exactly one cycle. Model i_busy high for 100 cycles, then i_done rises → STATUS = 0x2, CYCLES = 100, o_irq = 1. Write STATUS = 0x2 → o_irq = 0.
- With i_busy=1: write NUM_TRANS ← 32 → BRESP = SLVERR, register still 16. Write START → no o_start pulse.
- W1C of DONE on the same edge as an i_done rising edge → DONE stays 1. Pulse i_error for one cycle → ERR = 1 until W1C.
- BREADY/RREADY held low for 5 cycles → BVALID/RVALID and RDATA stable, AWREADY/ARREADY = 0. Assert reset mid-hold → all outputs return to reset values.
